// File: rtl/team_06_pkg.sv
// Shared types and helpers for the team_06 audio path.
//   current_effect_t : effect code driven by the talk/listen control FSM
//   lfo_dir_t        : tremolo LFO ramp direction
//   MIDPOINT         : offset-binary silence level
//   sat8()           : clamp a wide signed value to [-128,127]
package team_06_pkg;

    localparam int unsigned AUD_W = 8;
    localparam int unsigned ACC_W = 16;
    localparam int unsigned LFO_W = 6;

    localparam logic [AUD_W-1:0] MIDPOINT = 8'd128;
    localparam logic [LFO_W-1:0] LFO_MAX  = 6'd32;

    typedef enum logic [2:0] {
        EFF_NORMAL  = 3'd0,
        EFF_ECHO    = 3'd1,
        EFF_TREMOLO = 3'd2,
        EFF_REVERB  = 3'd3,
        EFF_SOFT    = 3'd4
    } current_effect_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } lfo_dir_t;

    // Saturate a signed accumulator value to the signed 8-bit sample range.
    function automatic logic signed [AUD_W-1:0] sat8(input logic signed [ACC_W-1:0] v);
        if (v > 16'sd127) begin
            sat8 = 8'sh7f;
        end else if (v < -16'sd128) begin
            sat8 = 8'sh80;
        end else begin
            sat8 = v[AUD_W-1:0];
        end
    endfunction

endpackage

// File: rtl/team_06_lfo.sv
// Triangle LFO for the tremolo effect: ramps 0..32..0 one step every
// LFO_DIV valid samples while enabled; held at 0 (direction up, divider 0)
// whenever disabled, so re-enabling always restarts the triangle.
//   clk, rst   : clock, synchronous active-high reset
//   en         : LFO running (tremolo selected and audio enabled)
//   step_valid : one valid sample has been consumed this cycle
//   lfo[5:0]   : current LFO value (registered), range 0..32
module team_06_lfo
    import team_06_pkg::*;
#(
    parameter int unsigned LFO_DIV = 256
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             step_valid,
    output logic [LFO_W-1:0] lfo
);

    localparam int unsigned DIV_W = (LFO_DIV > 1) ? $clog2(LFO_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(LFO_DIV - 1);

    lfo_dir_t         dir_q;
    lfo_dir_t         dir_d;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;
    logic [LFO_W-1:0] lfo_d;

    // State registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfo   <= '0;
            dir_q <= DIR_UP;
            div_q <= '0;
        end else begin
            lfo   <= lfo_d;
            dir_q <= dir_d;
            div_q <= div_d;
        end
    end

    // Divider and triangle stepping; direction flips on reaching either end.
    always_comb begin
        lfo_d = lfo;
        dir_d = dir_q;
        div_d = div_q;
        if (!en) begin
            lfo_d = '0;
            dir_d = DIR_UP;
            div_d = '0;
        end else if (step_valid) begin
            if (div_q == DIV_LAST) begin
                div_d = '0;
                if (dir_q == DIR_UP) begin
                    lfo_d = lfo + 6'd1;
                    if (lfo_d == LFO_MAX) begin
                        dir_d = DIR_DOWN;
                    end
                end else begin
                    lfo_d = lfo - 6'd1;
                    if (lfo_d == '0) begin
                        dir_d = DIR_UP;
                    end
                end
            end else begin
                div_d = div_q + DIV_W'(1);
            end
        end
    end

endmodule

// File: rtl/team_06_effect_proc.sv
// Audio effect engine between the team_06 control FSM and the transmit path.
// Applies NORMAL / ECHO / TREMOLO / REVERB / SOFT to the offset-binary mic
// stream with one cycle of latency per sample_valid strobe.
//   clk, rst          : clock, synchronous active-high reset
//   sample_valid      : mic_aud carries a new sample this cycle
//   mic_aud[7:0]      : mic sample, offset-binary (128 = silence)
//   effect_en         : 1 = transmitting; 0 forces silence out and into the delay line
//   current_effect[2:0]: effect select (codes 5..7 behave as NORMAL)
//   out_valid         : one-cycle strobe, out_aud was updated
//   out_aud[7:0]      : processed sample, offset-binary; holds between strobes
module team_06_effect_proc
    import team_06_pkg::*;
#(
    parameter int unsigned DEPTH   = 32,
    parameter int unsigned LFO_DIV = 256
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sample_valid,
    input  logic [7:0] mic_aud,
    input  logic       effect_en,
    input  logic [2:0] current_effect,
    output logic       out_valid,
    output logic [7:0] out_aud
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic signed [AUD_W-1:0] delay_q [DEPTH];
    logic [PTR_W-1:0]        wr_ptr;
    logic [LFO_W-1:0]        lfo;

    current_effect_t         eff_c;
    logic                    lfo_en_c;
    logic signed [8:0]       s_c;
    logic signed [AUD_W-1:0] d_c;
    logic signed [ACC_W-1:0] s_ext_c;
    logic signed [ACC_W-1:0] d_half_c;
    logic signed [ACC_W-1:0] gain_c;
    logic signed [ACC_W-1:0] y_c;
    logic signed [AUD_W-1:0] y_sat_c;
    logic signed [AUD_W-1:0] wr_data_c;
    logic [AUD_W-1:0]        aud_c;

    assign eff_c    = current_effect_t'(current_effect);
    assign lfo_en_c = effect_en && (eff_c == EFF_TREMOLO);

    // Tremolo LFO; runs only while tremolo is the active effect.
    team_06_lfo #(
        .LFO_DIV (LFO_DIV)
    ) u_lfo (
        .clk        (clk),
        .rst        (rst),
        .en         (lfo_en_c),
        .step_valid (sample_valid),
        .lfo        (lfo)
    );

    // Signed sample, delayed sample (read before this sample's write) and tremolo gain.
    assign s_c      = $signed({1'b0, mic_aud}) - 9'sd128;
    assign d_c      = delay_q[wr_ptr];
    assign s_ext_c  = $signed({{(ACC_W-9){s_c[8]}}, s_c});
    assign d_half_c = $signed({{(ACC_W-AUD_W){d_c[AUD_W-1]}}, d_c}) >>> 1;
    assign gain_c   = $signed(ACC_W'(7'd64 - {1'b0, lfo}));

    // Effect datapath: wet output and the value fed back into the delay line.
    always_comb begin
        y_c = s_ext_c;
        case (eff_c)
            EFF_ECHO, EFF_REVERB: y_c = s_ext_c + d_half_c;
            EFF_TREMOLO:          y_c = (s_ext_c * gain_c) >>> 6;
            EFF_SOFT:             y_c = s_ext_c >>> 1;
            default:              y_c = s_ext_c;
        endcase
        y_sat_c   = sat8(y_c);
        wr_data_c = $signed(s_c[AUD_W-1:0]);
        if (eff_c == EFF_REVERB) begin
            wr_data_c = y_sat_c;
        end
        aud_c = $unsigned(y_sat_c) + MIDPOINT;
        if (!effect_en) begin
            aud_c     = MIDPOINT;
            wr_data_c = '0;
        end
    end

    // Output register, delay line and write pointer; reset wins over a strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_aud   <= MIDPOINT;
            wr_ptr    <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                delay_q[i] <= '0;
            end
        end else begin
            out_valid <= sample_valid;
            if (sample_valid) begin
                out_aud         <= aud_c;
                delay_q[wr_ptr] <= wr_data_c;
                wr_ptr          <= wr_ptr + PTR_W'(1);
            end
        end
    end

endmodule

// File: doc/team_06_effect_proc.md
Name: team_06_effect_proc

Overview:
- Audio effect engine directly downstream of the team_06 talk/listen control FSM.
- Consumes the FSM's 3-bit `current_effect` code and its `effect_en` gate, and applies the selected effect to the live 8-bit offset-binary mic stream, one sample per `sample_valid` strobe.
- Its output feeds the transmit path.
- Effects: NORMAL, ECHO, TREMOLO, REVERB, SOFT. ECHO and REVERB use a flop-based delay line; TREMOLO uses a triangle LFO.

Parameters:
- DEPTH, 32, delay-line length in samples (power of two, ≥2).
- LFO_DIV, 256, valid samples per LFO step (≥1).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- sample_valid  in  1  one-cycle strobe: mic_aud holds a new sample
- mic_aud  in  8  mic sample, offset-binary, midpoint 128
- effect_en  in  1  from FSM; 1 = transmitting, process audio
- current_effect  in  3  from FSM: 0 NORMAL, 1 ECHO, 2 TREMOLO, 3 REVERB, 4 SOFT
- out_valid  out  1  one-cycle strobe: out_aud updated
- out_aud  out  8  processed sample, offset-binary

Behaviour:
- Reset (rst sampled high at posedge clk):
  - out_aud=128, out_valid=0.
  - All delay-line entries=0 (signed silence), wr_ptr=0.
  - LFO=0, LFO direction=up, LFO divider=0.
  - Synchronous and dominant: a sample_valid in the same cycle is dropped.
- Latency: exactly 1 cycle.
  - sample_valid at edge N → out_valid=1 and new out_aud visible after edge N.
  - out_valid deasserts the following cycle unless another strobe arrives.
  - Back-to-back strobes are legal. out_aud holds its value between strobes.
- Arithmetic:
  - s = mic_aud − 128 (signed 9-bit).
  - d = delay[wr_ptr], read before the write, i.e. the sample from DEPTH valid samples ago.
  - y is computed at ≥10-bit signed width, saturated to [−128,127], then out_aud = sat(y)+128.
  - All shifts are arithmetic.
- Per valid sample, by effect:
  - effect_en=0: out_aud=128, write 0 to delay[wr_ptr].
  - NORMAL (and illegal codes 5–7): y=s, write s.
  - ECHO: y=s+(d>>>1), write s (dry feed).
  - REVERB: y=s+(d>>>1), write sat(y) (feedback).
  - TREMOLO: y=(s*(64−lfo))>>>6, write s.
  - SOFT: y=s>>>1, write s.
- wr_ptr advances on every valid sample and wraps DEPTH−1→0.
- LFO (6-bit triangle, range 0..32):
  - Active only while effect_en=1 and current_effect=TREMOLO; otherwise it is held at 0 with direction=up and divider=0.
  - The divider counts valid samples; on reaching LFO_DIV−1 it wraps to 0 and the LFO steps ±1.
  - Direction reverses at 32 and at 0.
  - The gain uses the LFO value before the step. Period = 64·LFO_DIV samples.
- Effect change mid-stream: takes effect on the next valid sample. Delay-line contents are retained, so switching NORMAL→ECHO can emit echoes of earlier dry audio.
- No handshake back-pressure: the consumer must accept every out_valid.

Decomposition:
- team_06_pkg holds:
  - the current_effect_t enum (shared with the FSM);
  - MIDPOINT=8'd128;
  - a sat8 function (signed → [−128,127]).
- Sub-module team_06_lfo: triangle generator with ports clk, rst, en, step_valid, output lfo[5:0], parameter LFO_DIV.
- Delay line, pointer and datapath stay in team_06_effect_proc.

Test Plan:
- Reset/gate:
  - rst high with sample_valid high → out_valid=0, out_aud=128.
  - effect_en=0, NORMAL, mic_aud=200 → out_aud=128, 1 cycle later.
- ECHO, DEPTH=4, effect_en=1: impulse 228 then 128s → outputs 228,128,128,128,178,128,128…
- REVERB, DEPTH=4: same impulse → 228,128,128,128,178,128,128,128,153,128,128,128,140…
- Saturation, ECHO, DEPTH=4:
  - constant 255 → from 5th sample out_aud=255 (127+63 clipped).
  - constant 0 → 0 (−192 clipped to −128).
- SOFT: 200→164, 0→64, 255→191, 128→128. TREMOLO, LFO_DIV=1, constant 192:
  - sample k=0 → 192;
  - k=32 → 160;
  - k=64 → 192 (triangle returns).
  - Switching away and back restarts at lfo=0.
- Reset mid-operation: ECHO, DEPTH=4, impulse 228, 1-cycle rst, then 128s → all outputs 128, no echo ever appears; wr_ptr restarts at 0.
